// File: rtl/usb_pd_rx_ctrl.sv
// USB-PD protocol-layer receive controller: CRC qualify, GoodCRC request, MessageID filter, one-entry output buffer.
// Define USB_PD_RX_STATS_EN to implement the crc_err_cnt / dup_cnt / ovf_cnt saturating counters.
module usb_pd_rx_ctrl #(
  parameter int unsigned system_khz      = 200000,
  parameter int unsigned gcrc_timeout_us = 195
) (
  input  logic         clock,
  input  logic         nrst,
  input  logic         rd_pkg_valid,
  input  logic         rd_crc_valid,
  input  logic         rd_role,
  input  logic [2:0]   rd_msg_id,
  input  logic [2:0]   rd_msg_num,
  input  logic [3:0]   rd_msg_type,
  input  logic [223:0] rd_words,
  output logic         gcrc_req,
  output logic [2:0]   gcrc_id,
  input  logic         gcrc_ack,
  output logic         rx_goodcrc,
  output logic [2:0]   rx_goodcrc_id,
  output logic         rx_soft_reset,
  input  logic         soft_reset,
  output logic         msg_valid,
  input  logic         msg_ready,
  output logic         msg_role,
  output logic [2:0]   msg_id,
  output logic [2:0]   msg_num,
  output logic [3:0]   msg_type,
  output logic [223:0] msg_words,
  output logic [7:0]   crc_err_cnt,
  output logic [7:0]   dup_cnt,
  output logic [7:0]   ovf_cnt
);

  localparam int unsigned TMO_RAW = (system_khz * gcrc_timeout_us) / 1000;
  localparam int unsigned TMO_CYC = (TMO_RAW == 0) ? 1 : TMO_RAW;
  localparam int unsigned TW      = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  typedef struct packed {
    logic         role;
    logic [2:0]   id;
    logic [2:0]   num;
    logic [3:0]   mtype;
    logic [223:0] words;
  } msg_t;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_GREQ, S_FILTER} state_e;

  state_e        state_q, state_d;
  logic          pkg_q;
  msg_t          shadow_q, shadow_d, buf_q, buf_d;
  logic          msg_valid_q, msg_valid_d;
  logic [2:0]    last_id_q, last_id_d;
  logic          last_id_valid_q, last_id_valid_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          gcrc_req_q, gcrc_req_d;
  logic [2:0]    gcrc_id_q, gcrc_id_d;
  logic          rx_goodcrc_q, rx_goodcrc_d;
  logic [2:0]    rx_goodcrc_id_q, rx_goodcrc_id_d;
  logic          rx_soft_reset_q, rx_soft_reset_d;

  logic pkg_event_c, is_goodcrc_c, is_sr_c, is_dup_c, deliver_c;

  assign pkg_event_c  = rd_pkg_valid && !pkg_q;
  assign is_goodcrc_c = (shadow_q.mtype == 4'h1) && (shadow_q.num == 3'd0);
  assign is_sr_c      = (shadow_q.mtype == 4'hD) && (shadow_q.num == 3'd0);
  // A coincident soft_reset request wipes history before the duplicate compare
  assign is_dup_c     = last_id_valid_q && !soft_reset && (shadow_q.id == last_id_q);
  assign deliver_c    = (state_q == S_FILTER) && (is_sr_c || !is_dup_c);

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q         <= S_IDLE;
      pkg_q           <= 1'b0;
      shadow_q        <= '0;
      buf_q           <= '0;
      msg_valid_q     <= 1'b0;
      last_id_q       <= 3'd0;
      last_id_valid_q <= 1'b0;
      tmo_q           <= '0;
      gcrc_req_q      <= 1'b0;
      gcrc_id_q       <= 3'd0;
      rx_goodcrc_q    <= 1'b0;
      rx_goodcrc_id_q <= 3'd0;
      rx_soft_reset_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pkg_q           <= rd_pkg_valid;
      shadow_q        <= shadow_d;
      buf_q           <= buf_d;
      msg_valid_q     <= msg_valid_d;
      last_id_q       <= last_id_d;
      last_id_valid_q <= last_id_valid_d;
      tmo_q           <= tmo_d;
      gcrc_req_q      <= gcrc_req_d;
      gcrc_id_q       <= gcrc_id_d;
      rx_goodcrc_q    <= rx_goodcrc_d;
      rx_goodcrc_id_q <= rx_goodcrc_id_d;
      rx_soft_reset_q <= rx_soft_reset_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    shadow_d        = shadow_q;
    buf_d           = buf_q;
    msg_valid_d     = msg_valid_q;
    last_id_d       = last_id_q;
    last_id_valid_d = last_id_valid_q;
    tmo_d           = '0;
    rx_goodcrc_d    = 1'b0;
    rx_goodcrc_id_d = rx_goodcrc_id_q;
    rx_soft_reset_d = 1'b0;

    if (msg_valid_q && msg_ready) msg_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pkg_event_c && rd_crc_valid) begin
          shadow_d = '{role: rd_role, id: rd_msg_id, num: rd_msg_num,
                       mtype: rd_msg_type, words: rd_words};
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (is_goodcrc_c) begin
          rx_goodcrc_d    = 1'b1;
          rx_goodcrc_id_d = shadow_q.id;
          state_d         = S_IDLE;
        end else begin
          state_d = S_GREQ;
        end
      end
      S_GREQ: begin
        if (gcrc_ack) begin
          state_d = S_FILTER;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_FILTER: begin
        state_d = S_IDLE;
        if (is_sr_c) begin
          rx_soft_reset_d = 1'b1;
          last_id_valid_d = 1'b0;
        end else if (!is_dup_c) begin
          last_id_d       = shadow_q.id;
          last_id_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (soft_reset) last_id_valid_d = 1'b0;

    // Full buffer not being drained this cycle drops the new message
    if (deliver_c && !(msg_valid_q && !msg_ready)) begin
      buf_d       = shadow_q;
      msg_valid_d = 1'b1;
    end

    gcrc_req_d = (state_d == S_GREQ);
    gcrc_id_d  = (state_d == S_GREQ) ? shadow_q.id : 3'd0;
  end

  assign gcrc_req      = gcrc_req_q;
  assign gcrc_id       = gcrc_id_q;
  assign rx_goodcrc    = rx_goodcrc_q;
  assign rx_goodcrc_id = rx_goodcrc_id_q;
  assign rx_soft_reset = rx_soft_reset_q;
  assign msg_valid     = msg_valid_q;
  assign msg_role      = buf_q.role;
  assign msg_id        = buf_q.id;
  assign msg_num       = buf_q.num;
  assign msg_type      = buf_q.mtype;
  assign msg_words     = buf_q.words;

`ifdef USB_PD_RX_STATS_EN
  logic [7:0] crc_err_cnt_q, dup_cnt_q, ovf_cnt_q;
  logic       crc_inc_c, dup_inc_c;
  logic [1:0] ovf_inc_c;

  assign crc_inc_c = (state_q == S_IDLE) && pkg_event_c && !rd_crc_valid;
  assign dup_inc_c = (state_q == S_FILTER) && !is_sr_c && is_dup_c;
  assign ovf_inc_c = 2'(pkg_event_c && (state_q != S_IDLE))
                   + 2'((state_q == S_GREQ) && !gcrc_ack && (tmo_q == TMO_LAST))
                   + 2'(deliver_c && msg_valid_q && !msg_ready);

  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, c} + 9'(inc);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      crc_err_cnt_q <= 8'd0;
      dup_cnt_q     <= 8'd0;
      ovf_cnt_q     <= 8'd0;
    end else begin
      crc_err_cnt_q <= sat_add(crc_err_cnt_q, 2'(crc_inc_c));
      dup_cnt_q     <= sat_add(dup_cnt_q, 2'(dup_inc_c));
      ovf_cnt_q     <= sat_add(ovf_cnt_q, ovf_inc_c);
    end
  end

  assign crc_err_cnt = crc_err_cnt_q;
  assign dup_cnt     = dup_cnt_q;
  assign ovf_cnt     = ovf_cnt_q;
`else
  assign crc_err_cnt = 8'd0;
  assign dup_cnt     = 8'd0;
  assign ovf_cnt     = 8'd0;
`endif

endmodule

// File: tb/tb_usb_pd_rx_ctrl.sv
// Scoreboard bench for usb_pd_rx_ctrl: expected messages queued at send time, compared at consumer accept.
module tb_usb_pd_rx_ctrl;

`ifdef USB_PD_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic         role;
    logic [2:0]   id;
    logic [2:0]   num;
    logic [3:0]   mtype;
    logic [223:0] words;
  } exp_t;

  logic         clock = 1'b0;
  logic         nrst;
  logic         rd_pkg_valid, rd_crc_valid, rd_role;
  logic [2:0]   rd_msg_id, rd_msg_num;
  logic [3:0]   rd_msg_type;
  logic [223:0] rd_words;
  logic         gcrc_req, gcrc_ack, rx_goodcrc, rx_soft_reset, soft_reset;
  logic [2:0]   gcrc_id, rx_goodcrc_id;
  logic         msg_valid, msg_ready, msg_role;
  logic [2:0]   msg_id, msg_num;
  logic [3:0]   msg_type;
  logic [223:0] msg_words;
  logic [7:0]   crc_err_cnt, dup_cnt, ovf_cnt;

  usb_pd_rx_ctrl #(.system_khz(1000), .gcrc_timeout_us(10)) dut (
    .clock(clock), .nrst(nrst),
    .rd_pkg_valid(rd_pkg_valid), .rd_crc_valid(rd_crc_valid), .rd_role(rd_role),
    .rd_msg_id(rd_msg_id), .rd_msg_num(rd_msg_num), .rd_msg_type(rd_msg_type),
    .rd_words(rd_words),
    .gcrc_req(gcrc_req), .gcrc_id(gcrc_id), .gcrc_ack(gcrc_ack),
    .rx_goodcrc(rx_goodcrc), .rx_goodcrc_id(rx_goodcrc_id), .rx_soft_reset(rx_soft_reset),
    .soft_reset(soft_reset),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_role(msg_role), .msg_id(msg_id),
    .msg_num(msg_num), .msg_type(msg_type), .msg_words(msg_words),
    .crc_err_cnt(crc_err_cnt), .dup_cnt(dup_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  int   exp_crc = 0, exp_dup = 0, exp_ovf = 0;
  exp_t exp_q[$];

  int gcrc_cyc = 0, gc_pulses = 0, sr_pulses = 0;
  always @(posedge clock) begin
    if (gcrc_req)      gcrc_cyc  <= gcrc_cyc + 1;
    if (rx_goodcrc)    gc_pulses <= gc_pulses + 1;
    if (rx_soft_reset) sr_pulses <= sr_pulses + 1;
  end

  logic [268:0] all_out;
  assign all_out = {gcrc_req, gcrc_id, rx_goodcrc, rx_goodcrc_id, rx_soft_reset, msg_valid,
                    msg_role, msg_id, msg_num, msg_type, msg_words, crc_err_cnt, dup_cnt, ovf_cnt};

  task automatic send_pkt(input logic crc, input logic [2:0] id, input logic [2:0] num,
                          input logic [3:0] mt, input logic [223:0] w, input logic expect_it);
    exp_t e;
    @(negedge clock);
    rd_role = id[0]; rd_msg_id = id; rd_msg_num = num; rd_msg_type = mt; rd_words = w;
    rd_crc_valid = crc; rd_pkg_valid = 1'b1;
    if (expect_it) begin
      e = '{role: id[0], id: id, num: num, mtype: mt, words: w};
      exp_q.push_back(e);
    end
    repeat (2) @(negedge clock);
    rd_pkg_valid = 1'b0; rd_crc_valid = 1'b0;
  endtask

  task automatic serve_gcrc(input int dly, output bit seen, output logic [2:0] id_seen,
                            output bit dropped);
    for (int i = 0; i < 20 && !gcrc_req; i++) @(negedge clock);
    seen = gcrc_req; id_seen = gcrc_id; dropped = 1'b0;
    if (seen) begin
      repeat (dly) @(negedge clock);
      gcrc_ack = 1'b1;
      @(negedge clock);
      gcrc_ack = 1'b0;
      dropped = !gcrc_req;
    end
  endtask

  task automatic accept_msg(output bit ok, output exp_t got, output bit cleared);
    for (int i = 0; i < 30 && !msg_valid; i++) @(negedge clock);
    ok = msg_valid;
    got = {msg_role, msg_id, msg_num, msg_type, msg_words};
    cleared = 1'b0;
    if (ok) begin
      msg_ready = 1'b1;
      @(negedge clock);
      msg_ready = 1'b0;
      cleared = !msg_valid;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_out); end
  endtask

  task automatic test_delivery(input logic [2:0] id, input logic [2:0] num, input logic [3:0] mt,
                               input int dly);
    logic [223:0] w;
    bit seen, dropped, ok, cleared;
    logic [2:0] gid;
    exp_t got, e;
    w = '0;
    for (int k = 0; k < int'(num); k++) w[k*32 +: 32] = $urandom();
    send_pkt(1'b1, id, num, mt, w, 1'b1);
    serve_gcrc(dly, seen, gid, dropped);
    checks++;
    if (!seen || gid !== id || !dropped) begin
      errors++; $display("FAIL gcrc_handshake seen %0b id %0d dropped %0b want 1 %0d 1", seen, gid, dropped, id);
    end
    accept_msg(ok, got, cleared);
    e = exp_q.size() ? exp_q.pop_front() : '0;
    checks++;
    if (!ok || got !== e) begin
      errors++; $display("FAIL deliver_id%0d got %h want %h (valid %0b)", id, got, e, ok);
    end
    checks++;
    if (!cleared) begin errors++; $display("FAIL accept_clear msg_valid %0b want 0", msg_valid); end
  endtask

  task automatic test_dup();
    bit seen, dropped, never;
    logic [2:0] gid;
    send_pkt(1'b1, 3'd2, 3'd0, 4'h3, '0, 1'b0);
    serve_gcrc(0, seen, gid, dropped);
    checks++;
    if (!seen || gid !== 3'd2) begin errors++; $display("FAIL dup_gcrc seen %0b id %0d want 1 2", seen, gid); end
    never = 1'b1;
    repeat (10) begin @(negedge clock); if (msg_valid) never = 1'b0; end
    exp_dup++;
    checks++;
    if (!never) begin errors++; $display("FAIL dup_dropped msg_valid 1 want 0"); end
    checks++;
    if (dup_cnt !== (STATS ? 8'(exp_dup) : 8'd0)) begin
      errors++; $display("FAIL dup_cnt got %0d want %0d", dup_cnt, STATS ? exp_dup : 0);
    end
  endtask

  task automatic test_crc_err();
    int c0;
    c0 = gcrc_cyc;
    send_pkt(1'b0, 3'd3, 3'd0, 4'h3, '0, 1'b0);
    repeat (10) @(negedge clock);
    exp_crc++;
    checks++;
    if (gcrc_cyc != c0 || msg_valid !== 1'b0) begin
      errors++; $display("FAIL crc_err_silent gcrc_cycles %0d valid %0b want 0 0", gcrc_cyc - c0, msg_valid);
    end
    checks++;
    if (crc_err_cnt !== (STATS ? 8'(exp_crc) : 8'd0)) begin
      errors++; $display("FAIL crc_err_cnt got %0d want %0d", crc_err_cnt, STATS ? exp_crc : 0);
    end
  endtask

  task automatic test_goodcrc();
    int c0, p0;
    c0 = gcrc_cyc; p0 = gc_pulses;
    send_pkt(1'b1, 3'd5, 3'd0, 4'h1, '0, 1'b0);
    repeat (8) @(negedge clock);
    checks++;
    if (gc_pulses - p0 != 1 || rx_goodcrc_id !== 3'd5) begin
      errors++; $display("FAIL goodcrc_pulse pulses %0d id %0d want 1 5", gc_pulses - p0, rx_goodcrc_id);
    end
    checks++;
    if (gcrc_cyc != c0 || msg_valid !== 1'b0) begin
      errors++; $display("FAIL goodcrc_no_reply gcrc_cycles %0d valid %0b want 0 0", gcrc_cyc - c0, msg_valid);
    end
  endtask

  task automatic test_timeout();
    int c0;
    c0 = gcrc_cyc;
    send_pkt(1'b1, 3'd4, 3'd0, 4'h3, '0, 1'b0);
    repeat (20) @(negedge clock);
    exp_ovf++;
    checks++;
    if (gcrc_cyc - c0 != 10 || gcrc_req !== 1'b0) begin
      errors++; $display("FAIL timeout_req_cycles got %0d req %0b want 10 0", gcrc_cyc - c0, gcrc_req);
    end
    checks++;
    if (msg_valid !== 1'b0) begin errors++; $display("FAIL timeout_no_msg valid 1 want 0"); end
    checks++;
    if (ovf_cnt !== (STATS ? 8'(exp_ovf) : 8'd0)) begin
      errors++; $display("FAIL timeout_ovf_cnt got %0d want %0d", ovf_cnt, STATS ? exp_ovf : 0);
    end
  endtask

  task automatic test_soft_reset();
    int s0;
    s0 = sr_pulses;
    test_delivery(3'd0, 3'd0, 4'hD, 1);
    checks++;
    if (sr_pulses - s0 != 1) begin errors++; $display("FAIL soft_reset_pulse got %0d want 1", sr_pulses - s0); end
    test_delivery(3'd2, 3'd0, 4'h3, 0);
  endtask

  task automatic test_busy();
    bit seen, dropped, ok, cleared;
    logic [2:0] gid;
    exp_t got, e;
    send_pkt(1'b1, 3'd6, 3'd0, 4'h3, '0, 1'b1);
    serve_gcrc(0, seen, gid, dropped);
    for (int i = 0; i < 10 && !msg_valid; i++) @(negedge clock);
    send_pkt(1'b1, 3'd7, 3'd0, 4'h4, '0, 1'b0);
    serve_gcrc(0, seen, gid, dropped);
    repeat (4) @(negedge clock);
    exp_ovf++;
    checks++;
    if (ovf_cnt !== (STATS ? 8'(exp_ovf) : 8'd0)) begin
      errors++; $display("FAIL busy_ovf_cnt got %0d want %0d", ovf_cnt, STATS ? exp_ovf : 0);
    end
    accept_msg(ok, got, cleared);
    e = exp_q.size() ? exp_q.pop_front() : '0;
    checks++;
    if (!ok || got !== e || !cleared) begin
      errors++; $display("FAIL busy_keeps_first got %h want %h valid %0b cleared %0b", got, e, ok, cleared);
    end
  endtask

  task automatic test_back_to_back();
    bit seen, dropped, ok, cleared;
    logic [2:0] gid;
    exp_t got, e;
    send_pkt(1'b1, 3'd0, 3'd0, 4'h3, '0, 1'b1);
    send_pkt(1'b1, 3'd1, 3'd0, 4'h3, '0, 1'b0);
    serve_gcrc(0, seen, gid, dropped);
    exp_ovf++;
    checks++;
    if (!seen || gid !== 3'd0) begin errors++; $display("FAIL b2b_gcrc_id got %0d want 0", gid); end
    accept_msg(ok, got, cleared);
    e = exp_q.size() ? exp_q.pop_front() : '0;
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL b2b_first_msg got %h want %h", got, e); end
    repeat (8) @(negedge clock);
    checks++;
    if (msg_valid !== 1'b0 || ovf_cnt !== (STATS ? 8'(exp_ovf) : 8'd0)) begin
      errors++; $display("FAIL b2b_ignored valid %0b ovf %0d want 0 %0d", msg_valid, ovf_cnt, STATS ? exp_ovf : 0);
    end
  endtask

  task automatic test_soft_reset_input();
    @(negedge clock); soft_reset = 1'b1;
    @(negedge clock); soft_reset = 1'b0;
    test_delivery(3'd0, 3'd0, 4'h3, 0);
  endtask

  task automatic test_nrst_mid();
    send_pkt(1'b1, 3'd3, 3'd0, 4'h3, '0, 1'b0);
    checks++;
    if (gcrc_req !== 1'b1) begin errors++; $display("FAIL nrst_pre_greq req %0b want 1", gcrc_req); end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL nrst_async_outputs got %h want 0", all_out); end
    @(negedge clock); nrst = 1'b1;
    repeat (15) @(negedge clock);
    checks++;
    if (gcrc_req !== 1'b0 || msg_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL nrst_recovery req %0b valid %0b pending %0d want 0 0 0", gcrc_req, msg_valid, exp_q.size());
    end
  endtask

  initial begin
    nrst = 1'b0;
    rd_pkg_valid = 1'b0; rd_crc_valid = 1'b0; rd_role = 1'b0; rd_msg_id = '0; rd_msg_num = '0;
    rd_msg_type = '0; rd_words = '0; gcrc_ack = 1'b0; soft_reset = 1'b0; msg_ready = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    nrst = 1'b1;
    @(negedge clock);
    test_delivery(3'd1, 3'd2, 4'h1, 2);
    test_delivery(3'd2, 3'd0, 4'h3, 3);
    test_dup();
    test_crc_err();
    test_goodcrc();
    test_timeout();
    test_soft_reset();
    test_busy();
    test_back_to_back();
    test_soft_reset_input();
    test_nrst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

endmodule

// File: doc/usb_pd_rx_ctrl.md
Name: usb_pd_rx_ctrl

Overview:
- Protocol-layer receive controller directly downstream of the BMC/4b5b receive PHY.
- Consumes the PHY's decoded-packet outputs and qualifies each packet on CRC.
- Requests a GoodCRC reply from the TX path, filters duplicate MessageIDs, detects received GoodCRC and Soft_Reset messages, and presents each accepted message to the policy engine through a one-entry valid/ready buffer.

Parameters:
system_khz, 200000, system clock frequency in kHz
gcrc_timeout_us, 195, time allowed for the TX path to acknowledge a GoodCRC request; timeout cycles = system_khz*gcrc_timeout_us/1000

Ports:
clock  in  1  system clock
nrst  in  1  reset; asynchronous, active-low
rd_pkg_valid  in  1  PHY packet-complete flag; may stay high for several cycles
rd_crc_valid  in  1  PHY CRC-match flag; qualified when rd_pkg_valid rises
rd_role  in  1  PHY header PowerRole bit
rd_msg_id  in  3  PHY header MessageID
rd_msg_num  in  3  PHY header data-object count
rd_msg_type  in  4  PHY header message type
rd_words  in  224  PHY data objects, word0 in bits [31:0]
gcrc_req  out  1  GoodCRC transmit request to TX path
gcrc_id  out  3  MessageID to echo in the GoodCRC
gcrc_ack  in  1  TX path accepted the request
rx_goodcrc  out  1  one-cycle pulse: a GoodCRC was received
rx_goodcrc_id  out  3  MessageID of the received GoodCRC; held until next pulse
rx_soft_reset  out  1  one-cycle pulse: a Soft_Reset was received
soft_reset  in  1  policy-engine request to clear MessageID history
msg_valid  out  1  output buffer holds a message
msg_ready  in  1  consumer accepts the message
msg_role  out  1  buffered PowerRole
msg_id  out  3  buffered MessageID
msg_num  out  3  buffered object count
msg_type  out  4  buffered message type
msg_words  out  224  buffered data objects
crc_err_cnt  out  8  saturating count of CRC failures
dup_cnt  out  8  saturating count of duplicate messages dropped
ovf_cnt  out  8  saturating count of overflow or busy drops

Behaviour:
- Reset (nrst low, asynchronous):
  - FSM returns to IDLE.
  - All outputs are 0.
  - last_id_valid=0; timeout counter=0.
- Event: rising edge of rd_pkg_valid, detected against a registered copy of the flag.
- IDLE:
  - On event with rd_crc_valid=0: crc_err_cnt+1; stay in IDLE.
  - On event with rd_crc_valid=1: capture all rd_* inputs into a shadow register; go to CHECK.
- CHECK (1 cycle):
  - type=4'h1 and num=0 (GoodCRC): pulse rx_goodcrc, load rx_goodcrc_id; go to IDLE. No reply is requested.
  - Any other message: go to GREQ.
- GREQ:
  - gcrc_req=1 and gcrc_id=shadow id, both held stable until gcrc_ack.
  - On gcrc_ack: drop gcrc_req the next cycle; go to FILTER.
  - If the timeout counter reaches the limit before gcrc_ack: drop gcrc_req, discard the message, ovf_cnt+1; go to IDLE.
- FILTER (1 cycle):
  - Soft_Reset (type=4'hD, num=0): pulse rx_soft_reset, clear last_id_valid, always deliver.
  - Else if last_id_valid and id==last_id: dup_cnt+1; drop.
  - Else: last_id=id, last_id_valid=1, deliver.
- Deliver:
  - If msg_valid=1 and msg_ready=0 in that cycle: drop, ovf_cnt+1.
  - Otherwise load the buffer and set msg_valid=1 on the next edge.
  - Go to IDLE.
- Output buffer:
  - msg_valid clears on the cycle after msg_valid and msg_ready are both 1.
  - A same-cycle accept and load leaves msg_valid=1 holding the new message.
- Event while not in IDLE: ignored, ovf_cnt+1.
- soft_reset input: clears last_id_valid. If it coincides with FILTER, the clear wins and the message is delivered.
- All counters saturate at 8'hFF.
- Latency, event edge to msg_valid: 4 cycles plus the gcrc_ack wait.

Optional Feature:
USB_PD_RX_STATS_EN
- Defined: crc_err_cnt, dup_cnt and ovf_cnt are implemented as described.
- Undefined: the counter registers are removed and all three outputs are tied to 8'd0. All drop behaviour is unchanged.

Test Plan:
- Control msg type 4'h3, id 2, crc ok; gcrc_ack 3 cycles after gcrc_req -> gcrc_id=2; msg_valid with msg_type=3, msg_id=2.
- Same msg id 2 repeated after accept -> GoodCRC still requested; no msg_valid; dup_cnt=1.
- Packet with rd_crc_valid=0 -> no gcrc_req; crc_err_cnt=1.
- GoodCRC received (type 1, num 0, id 5) -> rx_goodcrc pulse, rx_goodcrc_id=5, no gcrc_req.
- gcrc_ack never asserted (system_khz=1000, gcrc_timeout_us=10) -> gcrc_req low after 10 cycles; ovf_cnt=1; no msg_valid.
- Soft_Reset received, then id 2 again; msg_ready held low with buffer full; nrst pulse mid-GREQ -> Soft_Reset delivered; later id 2 accepted; second message dropped with ovf_cnt+1; all outputs 0 immediately on nrst.
